// File: rtl/recibir_datos.sv
// -----------------------------------------------------------------------------
// recibir_datos
//
// UART receiver (8N1, LSB first, idle high) feeding a small frame parser.
// A frame is: HEADER, one ASCII digit '0'..'9', one raw data byte, TERM.
// A good frame loads comm_out (digit value 0-9) and datos and pulses valid for
// one cycle. A rejected frame pulses error for one cycle and leaves comm_out
// and datos untouched.
//
// Parameters
//   BAUD     clocks per bit
//   HEADER   frame start byte
//   TERM     frame end byte
//   TIMEOUT  maximum clocks between byte strobes inside a frame
//
// Ports
//   clk                in   system clock, rising edge
//   rst                in   asynchronous active-low reset
//   rx                 in   serial line (asynchronous to clk)
//   comm_out[7:0]      out  command number of the last good frame
//   datos[7:0]         out  data byte of the last good frame
//   valid              out  one-cycle pulse: new frame on comm_out/datos
//   error              out  one-cycle pulse: frame rejected
//   busy               out  receiver mid-byte or parser mid-frame
//   o_dbg_rx_state     out  receiver state (R_IDLE=0 .. R_BREAK=4)
//   o_dbg_parse_state  out  parser state (P_HUNT=0 .. P_TERM=3)
//
// Handshake: valid and error are single-cycle strobes with no back-pressure;
// comm_out and datos are stable from the valid edge until the next valid.
// -----------------------------------------------------------------------------
module recibir_datos #(
    parameter int         BAUD    = 434,
    parameter logic [7:0] HEADER  = 8'h24,
    parameter logic [7:0] TERM    = 8'h0D,
    parameter int         TIMEOUT = 20 * BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] comm_out,
    output logic [7:0] datos,
    output logic       valid,
    output logic       error,
    output logic       busy,
    output logic [2:0] o_dbg_rx_state,
    output logic [1:0] o_dbg_parse_state
);

    // Bit counter is at least 18 bits so BAUD up to 166667 never wraps.
    localparam int BCW = ($clog2(BAUD + 1) > 18) ? $clog2(BAUD + 1) : 18;
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BAUD - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(BAUD / 2 - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_BITS  = 3'd2,
        R_STOP  = 3'd3,
        R_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        P_HUNT = 2'd0,
        P_CMD  = 2'd1,
        P_DATA = 2'd2,
        P_TERM = 2'd3
    } parse_state_t;

    // Receiver registers
    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_d;
    rx_state_t       r_rstate;
    logic [BCW-1:0]  r_baud_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_byte_stb;
    logic            r_frm_err;

    // Parser registers
    parse_state_t    r_pstate;
    logic [TCW-1:0]  r_to_cnt;
    logic [7:0]      r_cmd;
    logic [7:0]      r_data;
    logic [7:0]      r_comm_out;
    logic [7:0]      r_datos;
    logic            r_valid;
    logic            r_error;

    logic            w_fall;
    logic            w_is_digit;

    // Falling edge seen on the synchronized line (previous high, now low).
    assign w_fall     = r_rx_d & ~r_rx_s2;
    // r_shift is stable while r_byte_stb is high, so it doubles as the byte.
    assign w_is_digit = (r_shift >= 8'h30) && (r_shift <= 8'h39);

    // -------------------------------------------------------------------------
    // Receiver: synchronizer, start validation, 8 data bits, stop check.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_rstate   <= R_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_byte_stb <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_byte_stb <= 1'b0;
            r_frm_err  <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (w_fall) begin
                        r_rstate   <= R_START;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                R_START: begin
                    // Re-check mid start bit; a high line means it was a glitch.
                    if (r_baud_cnt == HALF_LAST) begin
                        r_baud_cnt <= '0;
                        r_rstate   <= r_rx_s2 ? R_IDLE : R_BITS;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                R_BITS: begin
                    if (r_baud_cnt == BIT_LAST) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rx_s2, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rstate <= R_STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_baud_cnt == BIT_LAST) begin
                        r_baud_cnt <= '0;
                        if (r_rx_s2) begin
                            r_byte_stb <= 1'b1;
                            r_rstate   <= R_IDLE;
                        end else begin
                            r_frm_err  <= 1'b1;
                            r_rstate   <= R_BREAK;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                R_BREAK: begin
                    // A held-low line must return high before a new start.
                    if (r_rx_s2) begin
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Parser: HEADER, digit, data, TERM; inter-byte timeout inside a frame.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pstate   <= P_HUNT;
            r_to_cnt   <= '0;
            r_cmd      <= '0;
            r_data     <= '0;
            r_comm_out <= '0;
            r_datos    <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;

            if (r_pstate == P_HUNT || r_byte_stb) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (r_frm_err) begin
                // Framing errors while hunting are line noise, not frames.
                if (r_pstate != P_HUNT) begin
                    r_error  <= 1'b1;
                    r_pstate <= P_HUNT;
                end
            end else if (r_byte_stb) begin
                case (r_pstate)
                    P_HUNT: begin
                        if (r_shift == HEADER) begin
                            r_pstate <= P_CMD;
                        end
                    end
                    P_CMD: begin
                        if (w_is_digit) begin
                            r_cmd    <= r_shift - 8'h30;
                            r_pstate <= P_DATA;
                        end else if (r_shift == HEADER) begin
                            // Reject the old frame but treat this as a new start.
                            r_error  <= 1'b1;
                        end else begin
                            r_error  <= 1'b1;
                            r_pstate <= P_HUNT;
                        end
                    end
                    P_DATA: begin
                        r_data   <= r_shift;
                        r_pstate <= P_TERM;
                    end
                    P_TERM: begin
                        if (r_shift == TERM) begin
                            r_comm_out <= r_cmd;
                            r_datos    <= r_data;
                            r_valid    <= 1'b1;
                        end else begin
                            r_error    <= 1'b1;
                        end
                        r_pstate <= P_HUNT;
                    end
                    default: r_pstate <= P_HUNT;
                endcase
            end else if (r_pstate != P_HUNT && r_to_cnt == TO_LAST) begin
                r_error  <= 1'b1;
                r_pstate <= P_HUNT;
            end
        end
    end

    assign comm_out          = r_comm_out;
    assign datos             = r_datos;
    assign valid             = r_valid;
    assign error             = r_error;
    assign busy              = (r_rstate != R_IDLE) || (r_pstate != P_HUNT);
    assign o_dbg_rx_state    = r_rstate;
    assign o_dbg_parse_state = r_pstate;

endmodule

// File: tb/tb_recibir_datos.sv
`timescale 1ns/1ps
module tb_recibir_datos;

    localparam int         BAUD    = 16;
    localparam int         TIMEOUT = 320;
    localparam logic [7:0] HEADER  = 8'h24;
    localparam logic [7:0] TERM    = 8'h0D;
    localparam int         W       = 17;   // {is_valid, comm_out, datos}

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] comm_out;
    logic [7:0] datos;
    logic       valid;
    logic       error;
    logic       busy;
    logic [2:0] dbg_rx_state;
    logic [1:0] dbg_parse_state;

    always #5 clk = ~clk;

    recibir_datos #(
        .BAUD    (BAUD),
        .HEADER  (HEADER),
        .TERM    (TERM),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rx                (rx),
        .comm_out          (comm_out),
        .datos             (datos),
        .valid             (valid),
        .error             (error),
        .busy              (busy),
        .o_dbg_rx_state    (dbg_rx_state),
        .o_dbg_parse_state (dbg_parse_state)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Expected output events, in order of occurrence.
    logic [W-1:0] exp_q[$];
    // Bytes of the frame collected so far; empty means hunting for HEADER.
    logic [7:0]   frame_q[$];
    logic [7:0]   last_comm  = 8'h00;
    logic [7:0]   last_datos = 8'h00;

    function automatic void push_valid();
        exp_q.push_back({1'b1, last_comm, last_datos});
    endfunction

    function automatic void push_error();
        exp_q.push_back({1'b0, last_comm, last_datos});
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (frame_q.size() == 0) begin
            if (b == HEADER) frame_q.push_back(b);
            return;
        end
        frame_q.push_back(b);
        if (frame_q.size() == 2) begin
            if (!(b >= 8'h30 && b <= 8'h39)) begin
                push_error();
                frame_q.delete();
                if (b == HEADER) frame_q.push_back(b);
            end
        end else if (frame_q.size() == 4) begin
            if (b == TERM) begin
                last_comm  = frame_q[1] - 8'h30;
                last_datos = frame_q[2];
                push_valid();
            end else begin
                push_error();
            end
            frame_q.delete();
        end
    endfunction

    // Frame cut short by a framing error or an inter-byte timeout.
    function automatic void model_abort();
        if (frame_q.size() != 0) push_error();
        frame_q.delete();
    endfunction

    function automatic void model_reset();
        frame_q.delete();
        last_comm  = 8'h00;
        last_datos = 8'h00;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] t);
        send_byte(HEADER); idle(3);
        send_byte(c);      idle(3);
        send_byte(d);      idle(3);
        send_byte(t);      idle(5);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected events never seen, required 0 pending", name, exp_q.size());
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        if (rst && (valid || error)) begin
            checks++;
            if (valid && error) begin
                failures++;
                $display("FAIL event_exclusive: valid=1 error=1, required at most one high");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event_unexpected: valid=%0b error=%0b comm_out=%0d datos=%02h, required no event",
                         valid, error, comm_out, datos);
            end else begin
                e = exp_q.pop_front();
                if (valid !== e[16] || comm_out !== e[15:8] || datos !== e[7:0]) begin
                    failures++;
                    $display("FAIL event_match: valid=%0b comm_out=%0d datos=%02h, required valid=%0b comm_out=%0d datos=%02h",
                             valid, comm_out, datos, e[16], e[15:8], e[7:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_comm_out", comm_out, 8'h00);
        check("reset_datos", datos, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_error", error, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_dbg_states", {dbg_rx_state, dbg_parse_state}, 5'd0);
        rst = 1'b1;
        idle(20);
        check("idle_busy", busy, 1'b0);

        // Basic good frame.
        send_frame(8'h33, 8'hA5, TERM);
        drain("good_frame");
        check("good_comm_out", comm_out, 8'd3);
        check("good_datos", datos, 8'hA5);

        // Bad command byte: rejected, outputs held, then a good frame.
        send_frame(8'h58, 8'h11, TERM);
        drain("bad_cmd");
        check("bad_cmd_hold_comm", comm_out, 8'd3);
        check("bad_cmd_hold_datos", datos, 8'hA5);
        send_frame(8'h39, 8'h5A, TERM);
        drain("after_bad_cmd");
        check("after_bad_comm", comm_out, 8'd9);

        // Terminator value as data.
        send_frame(8'h37, TERM, TERM);
        drain("term_as_data");
        check("term_data_comm", comm_out, 8'd7);
        check("term_data_datos", datos, 8'h0D);

        // Inter-byte timeout.
        send_byte(HEADER); idle(3);
        send_byte(8'h32);
        model_abort();
        idle(400);
        drain("timeout");
        check("timeout_busy", busy, 1'b0);
        check("timeout_hold_comm", comm_out, 8'd7);

        // Short glitch: no byte, no event.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_busy", busy, 1'b0);
        check("glitch_no_event", exp_q.size(), 0);

        // Line held low 12 bit-times during the data byte.
        send_byte(HEADER); idle(3);
        send_byte(8'h32);
        model_abort();
        rx = 1'b0;
        repeat (170) @(negedge clk);
        check("break_busy_low", busy, 1'b1);
        repeat (22) @(negedge clk);
        idle(10);
        drain("break");
        check("break_busy_released", busy, 1'b0);
        send_frame(8'h34, 8'h3C, TERM);
        drain("after_break");
        check("after_break_comm", comm_out, 8'd4);
        check("after_break_datos", datos, 8'h3C);

        // Reset in the middle of the data byte.
        send_byte(HEADER); idle(3);
        send_byte(8'h35); idle(3);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("midreset_comm_out", comm_out, 8'h00);
        check("midreset_datos", datos, 8'h00);
        check("midreset_busy", busy, 1'b0);
        check("midreset_valid_error", {valid, error}, 2'b00);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(10);
        send_frame(8'h36, 8'hC3, TERM);
        drain("after_reset");
        check("after_reset_comm", comm_out, 8'd6);
        check("after_reset_datos", datos, 8'hC3);

        // Randomized frames, some corrupted, some cut by a timeout.
        for (int f = 0; f < 40; f++) begin
            logic [7:0] h, c, d, t;
            h = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : HEADER;
            c = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'(8'h30 + $urandom_range(0, 9));
            d = 8'($urandom_range(0, 255));
            t = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : TERM;
            send_byte(h); idle($urandom_range(0, 40));
            send_byte(c);
            if ($urandom_range(0, 7) == 0) begin
                model_abort();
                idle(TIMEOUT + 30);
            end else begin
                idle($urandom_range(0, 40));
            end
            send_byte(d); idle($urandom_range(0, 40));
            send_byte(t); idle($urandom_range(0, 40));
        end
        model_abort();
        idle(TIMEOUT + 30);
        drain("random_frames");
        check("random_final_comm", comm_out, last_comm);
        check("random_final_datos", datos, last_datos);
        check("random_final_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
